// File: rtl/jtag_tap_ctrl_if.sv
// Serial JTAG pins between a test master (VIP / probe) and the device-side TAP.
interface jtag_tap_ctrl_if;
  logic tms;
  logic tdi;
  logic tdo;
  logic tdo_en;

  modport master (output tms, output tdi, input tdo, input tdo_en);
  modport slave  (input tms, input tdi, output tdo, output tdo_en);
endinterface

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1-style TAP controller: 16-state FSM, IR, IDCODE, BYPASS and an optional USER DR.
// Optional USER data register is built only when JTAG_USER_DR_EN is defined.
module jtag_tap_ctrl #(
  parameter int                 IR_LEN     = 4,
  parameter int                 DR_WIDTH   = 16,
  parameter logic [31:0]        IDCODE_VAL = 32'h4BA0_0477,
  parameter logic [IR_LEN-1:0]  IR_IDCODE  = 4'h1,
  parameter logic [IR_LEN-1:0]  IR_USER    = 4'h2
) (
  input  logic                clk,
  input  logic                rst,
  jtag_tap_ctrl_if.slave      jtag,
  output logic [3:0]          tap_state,
  output logic [IR_LEN-1:0]   ir_q,
  input  logic [DR_WIDTH-1:0] user_capture_i,
  output logic [DR_WIDTH-1:0] user_dr_o,
  output logic                user_update_o
);

  typedef enum logic [3:0] {
    TLR    = 4'hF, RTI    = 4'hC,
    SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
    PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
    SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR = 4'hA, EX1_IR = 4'h9,
    PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
  } tap_state_e;

  tap_state_e          state_q, state_d;
  logic [IR_LEN-1:0]   ir_d;
  logic [IR_LEN-1:0]   ir_sr_q, ir_sr_d;
  logic [31:0]         id_sr_q, id_sr_d;
  logic                byp_q, byp_d;
  logic [DR_WIDTH-1:0] user_sr_q, user_sr_d;
  logic [DR_WIDTH-1:0] user_dr_q, user_dr_d;
  logic                user_update_q, user_update_d;
  logic                sel_idcode, sel_user;

  assign sel_idcode = (ir_q == IR_IDCODE);
`ifdef JTAG_USER_DR_EN
  assign sel_user   = (ir_q == IR_USER) && !sel_idcode;
`else
  logic unused_user;
  assign sel_user    = 1'b0;
  assign unused_user = ^user_capture_i ^ (ir_q == IR_USER);
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:    state_d = jtag.tms ? TLR    : RTI;
      RTI:    state_d = jtag.tms ? SEL_DR : RTI;
      SEL_DR: state_d = jtag.tms ? SEL_IR : CAP_DR;
      CAP_DR: state_d = jtag.tms ? EX1_DR : SH_DR;
      SH_DR:  state_d = jtag.tms ? EX1_DR : SH_DR;
      EX1_DR: state_d = jtag.tms ? UPD_DR : PAU_DR;
      PAU_DR: state_d = jtag.tms ? EX2_DR : PAU_DR;
      EX2_DR: state_d = jtag.tms ? UPD_DR : SH_DR;
      UPD_DR: state_d = jtag.tms ? SEL_DR : RTI;
      SEL_IR: state_d = jtag.tms ? TLR    : CAP_IR;
      CAP_IR: state_d = jtag.tms ? EX1_IR : SH_IR;
      SH_IR:  state_d = jtag.tms ? EX1_IR : SH_IR;
      EX1_IR: state_d = jtag.tms ? UPD_IR : PAU_IR;
      PAU_IR: state_d = jtag.tms ? EX2_IR : PAU_IR;
      EX2_IR: state_d = jtag.tms ? UPD_IR : SH_IR;
      UPD_IR: state_d = jtag.tms ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  always_comb begin
    ir_d          = ir_q;
    ir_sr_d       = ir_sr_q;
    id_sr_d       = id_sr_q;
    byp_d         = byp_q;
    user_sr_d     = user_sr_q;
    user_dr_d     = user_dr_q;
    user_update_d = 1'b0;

    case (state_q)
      CAP_IR: begin
        ir_sr_d    = '0;
        ir_sr_d[0] = 1'b1;
      end
      SH_IR: begin
        ir_sr_d             = ir_sr_q >> 1;
        ir_sr_d[IR_LEN-1]   = jtag.tdi;
      end
      UPD_IR: ir_d = ir_sr_q;
      CAP_DR: begin
        if (sel_idcode)    id_sr_d   = IDCODE_VAL;
        else if (sel_user) user_sr_d = user_capture_i;
        else               byp_d     = 1'b0;
      end
      SH_DR: begin
        if (sel_idcode) begin
          id_sr_d     = id_sr_q >> 1;
          id_sr_d[31] = jtag.tdi;
        end else if (sel_user) begin
          user_sr_d             = user_sr_q >> 1;
          user_sr_d[DR_WIDTH-1] = jtag.tdi;
        end else begin
          byp_d = jtag.tdi;
        end
      end
      UPD_DR: begin
        if (sel_user) begin
          user_dr_d     = user_sr_q;
          user_update_d = 1'b1;
        end
      end
      default: ;
    endcase

    // Any path into Test-Logic-Reset restores the instruction and clears the scan chains.
    if (state_d == TLR) begin
      ir_d      = IR_IDCODE;
      ir_sr_d   = '0;
      id_sr_d   = '0;
      byp_d     = 1'b0;
      user_sr_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= TLR;
      ir_q          <= IR_IDCODE;
      ir_sr_q       <= '0;
      id_sr_q       <= '0;
      byp_q         <= 1'b0;
      user_sr_q     <= '0;
      user_dr_q     <= '0;
      user_update_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      ir_sr_q       <= ir_sr_d;
      id_sr_q       <= id_sr_d;
      byp_q         <= byp_d;
      user_sr_q     <= user_sr_d;
      user_dr_q     <= user_dr_d;
      user_update_q <= user_update_d;
    end
  end

  always_comb begin
    jtag.tdo    = 1'b0;
    jtag.tdo_en = 1'b0;
    if (state_q == SH_IR) begin
      jtag.tdo    = ir_sr_q[0];
      jtag.tdo_en = 1'b1;
    end else if (state_q == SH_DR) begin
      jtag.tdo_en = 1'b1;
      if (sel_idcode)    jtag.tdo = id_sr_q[0];
      else if (sel_user) jtag.tdo = user_sr_q[0];
      else               jtag.tdo = byp_q;
    end
  end

  assign tap_state     = state_q;
`ifdef JTAG_USER_DR_EN
  assign user_dr_o     = user_dr_q;
  assign user_update_o = user_update_q;
`else
  assign user_dr_o     = '0;
  assign user_update_o = 1'b0;
`endif

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: reset, IDCODE, BYPASS, IR capture/TLR escape, USER DR, mid-shift reset.
module tb_jtag_tap_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  tap_state;
  logic [3:0]  ir_q;
  logic [15:0] user_capture_i;
  logic [15:0] user_dr_o;
  logic        user_update_o;
  int          total = 0;
  int          bad   = 0;

  jtag_tap_ctrl_if jif();

  jtag_tap_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .jtag           (jif),
    .tap_state      (tap_state),
    .ir_q           (ir_q),
    .user_capture_i (user_capture_i),
    .user_dr_o      (user_dr_o),
    .user_update_o  (user_update_o)
  );

  always #5 clk = ~clk;

  task automatic step(input logic t, input logic d);
    jif.tms = t;
    jif.tdi = d;
    @(posedge clk);
    #1;
  endtask

  // From RTI: scan n DR bits (LSB first), exit through Update-DR back to RTI.
  task automatic shift_dr(input int n, input logic [31:0] din, output logic [31:0] cap,
                          output int en_cnt, output int upd_cnt);
    cap = '0; en_cnt = 0; upd_cnt = 0;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < n; i++) begin
      cap[i] = jif.tdo;
      if (jif.tdo_en === 1'b1) en_cnt++;
      step((i == n - 1) ? 1'b1 : 1'b0, din[i]);
    end
    step(1, 0);
    if (user_update_o === 1'b1) upd_cnt++;
    step(0, 0);
    if (user_update_o === 1'b1) upd_cnt++;
    step(0, 0);
    if (user_update_o === 1'b1) upd_cnt++;
  endtask

  // From RTI: load a 4-bit instruction, return to RTI.
  task automatic shift_ir(input logic [3:0] din, output logic [3:0] cap);
    cap = '0;
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) begin
      cap[i] = jif.tdo;
      step((i == 3) ? 1'b1 : 1'b0, din[i]);
    end
    step(1, 0);
    step(0, 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(0, 0);
    rst = 1'b0;
    total++; if (tap_state !== 4'hF) begin bad++; $display("FAIL reset_state got=%h exp=F", tap_state); end
    total++; if (ir_q !== 4'h1) begin bad++; $display("FAIL reset_ir got=%h exp=1", ir_q); end
    total++; if (jif.tdo_en !== 1'b0) begin bad++; $display("FAIL reset_tdo_en got=%b exp=0", jif.tdo_en); end
    total++; if (user_dr_o !== 16'h0 || user_update_o !== 1'b0) begin
      bad++; $display("FAIL reset_user got=%h/%b exp=0000/0", user_dr_o, user_update_o); end
  endtask

  task automatic test_idcode();
    logic [31:0] cap;
    int en, upd;
    step(0, 0);
    total++; if (tap_state !== 4'hC) begin bad++; $display("FAIL rti_state got=%h exp=C", tap_state); end
    shift_dr(32, 32'h0, cap, en, upd);
    total++; if (cap !== 32'h4BA0_0477) begin bad++; $display("FAIL idcode got=%h exp=4ba00477", cap); end
    total++; if (en !== 32) begin bad++; $display("FAIL idcode_tdo_en got=%0d exp=32", en); end
    total++; if (jif.tdo_en !== 1'b0) begin bad++; $display("FAIL tdo_en_idle got=%b exp=0", jif.tdo_en); end
  endtask

  task automatic test_bypass();
    logic [31:0] cap;
    logic [3:0]  icap;
    int en, upd;
    shift_ir(4'hF, icap);
    total++; if (ir_q !== 4'hF) begin bad++; $display("FAIL ir_load got=%h exp=F", ir_q); end
    shift_dr(9, 32'h0A5, cap, en, upd);
    total++; if (cap[8:0] !== 9'h14A) begin bad++; $display("FAIL bypass got=%h exp=14a", cap[8:0]); end
  endtask

  task automatic test_ir_capture_tlr();
    step(1, 0); step(1, 0); step(0, 0); step(0, 0);
    total++; if (tap_state !== 4'hA || jif.tdo_en !== 1'b1) begin
      bad++; $display("FAIL shir_entry got=%h/%b exp=A/1", tap_state, jif.tdo_en); end
    total++; if (jif.tdo !== 1'b1) begin bad++; $display("FAIL ir_cap_bit0 got=%b exp=1", jif.tdo); end
    step(0, 0);
    total++; if (jif.tdo !== 1'b0) begin bad++; $display("FAIL ir_cap_bit1 got=%b exp=0", jif.tdo); end
    for (int i = 0; i < 5; i++) step(1, 1);
    total++; if (tap_state !== 4'hF) begin bad++; $display("FAIL tms5_state got=%h exp=F", tap_state); end
    total++; if (ir_q !== 4'h1) begin bad++; $display("FAIL tms5_ir got=%h exp=1", ir_q); end
    step(0, 0);
  endtask

  task automatic test_user();
    logic [31:0] cap;
    logic [3:0]  icap;
    int en, upd;
    user_capture_i = 16'hBEEF;
    shift_ir(4'h2, icap);
    total++; if (ir_q !== 4'h2) begin bad++; $display("FAIL user_ir got=%h exp=2", ir_q); end
    shift_dr(16, 32'h1234, cap, en, upd);
`ifdef JTAG_USER_DR_EN
    total++; if (cap[15:0] !== 16'hBEEF) begin bad++; $display("FAIL user_capture got=%h exp=beef", cap[15:0]); end
    total++; if (user_dr_o !== 16'h1234) begin bad++; $display("FAIL user_dr got=%h exp=1234", user_dr_o); end
    total++; if (upd !== 1) begin bad++; $display("FAIL user_strobe got=%0d exp=1", upd); end
`else
    total++; if (cap[15:0] !== 16'h2468) begin bad++; $display("FAIL user_bypass got=%h exp=2468", cap[15:0]); end
    total++; if (user_dr_o !== 16'h0) begin bad++; $display("FAIL user_dr got=%h exp=0000", user_dr_o); end
    total++; if (upd !== 0) begin bad++; $display("FAIL user_strobe got=%0d exp=0", upd); end
`endif
  endtask

  task automatic test_rst_mid_shift();
    user_capture_i = 16'hCAFE;
    step(1, 0); step(0, 0); step(0, 0);
    for (int i = 0; i < 4; i++) step(0, 1);
    total++; if (tap_state !== 4'h2) begin bad++; $display("FAIL mid_shdr got=%h exp=2", tap_state); end
    rst = 1'b1;
    step(0, 0);
    rst = 1'b0;
    total++; if (tap_state !== 4'hF || ir_q !== 4'h1) begin
      bad++; $display("FAIL mid_rst_state got=%h/%h exp=F/1", tap_state, ir_q); end
    total++; if (user_dr_o !== 16'h0 || user_update_o !== 1'b0) begin
      bad++; $display("FAIL mid_rst_user got=%h/%b exp=0000/0", user_dr_o, user_update_o); end
    step(1, 0);
    total++; if (user_update_o !== 1'b0 || tap_state !== 4'hF || jif.tdo_en !== 1'b0) begin
      bad++; $display("FAIL post_rst got=%b/%h/%b exp=0/F/0", user_update_o, tap_state, jif.tdo_en); end
  endtask

  initial begin
    rst = 1'b0;
    jif.tms = 1'b1;
    jif.tdi = 1'b0;
    user_capture_i = 16'h0;
    @(posedge clk);
    #1;
    test_reset();
    test_idcode();
    test_bypass();
    test_ir_capture_tlr();
    test_user();
    test_rst_mid_shift();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/jtag_tap_ctrl.md
Name: jtag_tap_ctrl

Overview:
- Parametrised IEEE 1149.1-style TAP controller that sits as the device side of the JTAG interface (tck, tms, tdi, tdo, tdo_en).
- Implements the 16-state TAP FSM, an IR of IR_LEN bits, IDCODE and BYPASS data registers, and one USER data register of DR_WIDTH bits with parallel capture and update ports.
- Serves as both the DUT-side responder for the JTAG VIP and the reusable TAP for core debug blocks.

Parameters:
- IR_LEN, 4, instruction register width (>=2).
- DR_WIDTH, 16, USER data register width (>=1).
- IDCODE_VAL, 32'h4BA0_0477, IDCODE register value; bit0 must be 1.
- IR_IDCODE, 4'h1, IDCODE opcode (IR_LEN bits).
- IR_USER, 4'h2, USER opcode (IR_LEN bits).

Ports:
- clk  input  1  TCK; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- tms  input  1  test mode select.
- tdi  input  1  serial data in.
- tdo  output  1  serial data out.
- tdo_en  output  1  high while in Shift-DR or Shift-IR.
- tap_state  output  4  current FSM state encoding.
- ir_q  output  IR_LEN  current (updated) instruction.
- user_capture_i  input  DR_WIDTH  value loaded into the USER shift register in Capture-DR.
- user_dr_o  output  DR_WIDTH  USER register contents latched in Update-DR.
- user_update_o  output  1  one-cycle strobe when user_dr_o is written.

Behaviour:
- Interface decision: one clock (clk); reset rst is synchronous and active-high.
- State encoding:
  - TLR=F, RTI=C, SelDR=7, CapDR=6, ShDR=2, Ex1DR=1, PauDR=3, Ex2DR=0, UpdDR=5
  - SelIR=4, CapIR=E, ShIR=A, Ex1IR=9, PauIR=B, Ex2IR=8, UpdIR=D
- Transitions per 1149.1 on each clk rising edge, sampled tms:
  - TLR: 1->TLR, 0->RTI. RTI: 1->SelDR, 0->RTI.
  - SelDR: 1->SelIR, 0->CapDR. SelIR: 1->TLR, 0->CapIR.
  - Cap: 1->Ex1, 0->Sh. Sh: 1->Ex1, 0->Sh.
  - Ex1: 1->Upd, 0->Pau. Pau: 1->Ex2, 0->Pau.
  - Ex2: 1->Upd, 0->Sh. Upd: 1->SelDR, 0->RTI.
- Any state with tms=1 for 5 consecutive edges reaches TLR.
- Reset values when rst=1, or on entering TLR:
  - tap_state=F, ir_q=IR_IDCODE, shift registers 0, tdo_en=0.
  - rst only: user_dr_o=0, user_update_o=0.
- Reset applies mid-operation with no partial update.
- IR path:
  - CapIR loads shift register with {0..0,2'b01}.
  - ShIR shifts right each edge; tdi enters the MSB.
  - UpdIR copies shift register to ir_q.
- DR selection decoded from ir_q:
  - IR_IDCODE -> 32-bit IDCODE register.
  - IR_USER -> DR_WIDTH USER register.
  - All-ones and any other opcode -> 1-bit BYPASS.
- DR capture values in CapDR:
  - IDCODE register <- IDCODE_VAL.
  - USER register <- user_capture_i.
  - BYPASS <- 0.
- ShDR shifts the selected register right, tdi into the MSB.
- UpdDR with USER selected: user_dr_o <- shift register; user_update_o=1 for exactly that cycle. No other register has an update effect.
- tdo:
  - Combinational: LSB of the active shift register (IR in ShIR, selected DR in ShDR), else 0.
  - First captured bit is therefore visible throughout the Shift state before the first shifting edge.
- Pause and Exit states hold shift register contents unchanged.

Optional Feature:
- Macro: JTAG_USER_DR_EN.
- Defined: USER register and ports behave as above.
- Undefined:
  - IR_USER decodes to BYPASS.
  - user_dr_o is held 0 and user_update_o is never asserted.
  - user_capture_i is ignored; no USER register is synthesised.

Test Plan:
- rst=1 for 1 cycle -> tap_state=F, ir_q=4'h1, tdo_en=0, user_dr_o=0.
- From reset, navigate to ShDR and shift 32 bits -> tdo LSB-first stream equals 32'h4BA0_0477; tdo_en=1 only during ShDR.
- Load IR=4'hF, then shift 8'hA5 through DR -> tdo returns 0 followed by 8'hA5 delayed by one bit.
- From ShIR, drive tms=1 for 5 edges -> tap_state=F; ir_q reverts to 4'h1. Also, the first 2 tdo bits in ShIR are 1,0 (capture pattern 01).
- IR=4'h2, user_capture_i=16'hBEEF, shift in 16'h1234 -> tdo emits 16'hBEEF; UpdDR gives user_dr_o=16'h1234 with a one-cycle user_update_o. With JTAG_USER_DR_EN undefined -> 1-bit bypass behaviour and no strobe.
- Assert rst mid-ShDR -> next cycle tap_state=F, user_dr_o=0, no update strobe.
